// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter that locks a grant until last, request drop or hold limit.
// Latency: registered grant, visible one cycle after the deciding clock edge.
// Backpressure: none; level-sensitive requests simply wait until they win.
module rr_lock_arbiter #(
    parameter int REQWIDTH = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [(2**REQWIDTH)-1:0]   req_i,
    input  logic                       last_i,
    output logic [(2**REQWIDTH)-1:0]   gnt_o,
    output logic [REQWIDTH-1:0]        gnt_num_o,
    output logic                       gnt_valid_o,
    output logic                       timeout_o
);

    localparam int N  = 2**REQWIDTH;
    // Keep the counter at least one bit wide when the hold limit is disabled.
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_ONE = HW'(1);
    // Without a limit the counter only needs to stop wrapping, so park it at all-ones.
    localparam logic [HW-1:0] HOLD_SAT = (MAX_HOLD > 0) ? HW'(MAX_HOLD) : {HW{1'b1}};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    logic [0:0]          state_q,    state_d;
    logic [REQWIDTH-1:0] ptr_q,      ptr_d;
    logic [HW-1:0]       hold_cnt_q, hold_cnt_d;
    logic [N-1:0]        gnt_q,      gnt_d;
    logic [REQWIDTH-1:0] gnt_num_q,  gnt_num_d;
    logic                gnt_vld_q,  gnt_vld_d;
    logic                timeout_q,  timeout_d;

    logic [REQWIDTH-1:0] search_base;
    logic [REQWIDTH-1:0] next_ptr;
    logic                win_found;
    logic [REQWIDTH-1:0] win_idx;
    logic                limit_hit;
    logic                cur_req;
    logic                rel;

    // First requester at or after base, scanning upward with modulo-N wrap.
    // The index adder is REQWIDTH bits wide, so the wrap falls out of the arithmetic.
    function automatic logic [REQWIDTH:0] pick_winner(
        input logic [N-1:0]        req,
        input logic [REQWIDTH-1:0] base
    );
        logic                found;
        logic [REQWIDTH-1:0] idx;
        logic [REQWIDTH-1:0] cand;
        found = 1'b0;
        idx   = '0;
        for (int k = 0; k < N; k++) begin
            cand = base + REQWIDTH'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        return {found, idx};
    endfunction

    // Release detection and winner search for the next grant.
    always_comb begin
        next_ptr  = gnt_num_q + REQWIDTH'(1);
        cur_req   = req_i[gnt_num_q];
        limit_hit = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LIM);
        rel       = (state_q == ST_BUSY) && (last_i || !cur_req || limit_hit);
        // On a handover the search starts just past the outgoing winner, so it is
        // considered last; from idle the stored pointer is used as-is.
        search_base = (state_q == ST_BUSY) ? next_ptr : ptr_q;
        {win_found, win_idx} = pick_winner(req_i, search_base);
    end

    // Next-state logic: grant from idle, hold/count while locked, hand over on release.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_num_d  = gnt_num_q;
        gnt_vld_d  = gnt_vld_q;
        // A forced release is only a timeout when nothing else would have ended it.
        timeout_d  = rel && limit_hit && !last_i && cur_req;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    state_d          = ST_BUSY;
                    gnt_d            = '0;
                    gnt_d[win_idx]   = 1'b1;
                    gnt_num_d        = win_idx;
                    gnt_vld_d        = 1'b1;
                    hold_cnt_d       = HOLD_ONE;
                end else begin
                    gnt_d      = '0;
                    gnt_num_d  = '0;
                    gnt_vld_d  = 1'b0;
                    hold_cnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (rel) begin
                    ptr_d = next_ptr;
                    if (win_found) begin
                        // Back-to-back handover, no idle bubble.
                        gnt_d          = '0;
                        gnt_d[win_idx] = 1'b1;
                        gnt_num_d      = win_idx;
                        gnt_vld_d      = 1'b1;
                        hold_cnt_d     = HOLD_ONE;
                    end else begin
                        state_d    = ST_IDLE;
                        gnt_d      = '0;
                        gnt_num_d  = '0;
                        gnt_vld_d  = 1'b0;
                        hold_cnt_d = '0;
                    end
                end else if (hold_cnt_q != HOLD_SAT) begin
                    hold_cnt_d = hold_cnt_q + HOLD_ONE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                gnt_d      = '0;
                gnt_num_d  = '0;
                gnt_vld_d  = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State registers; reset wins over any grant in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            hold_cnt_q <= '0;
            gnt_q      <= '0;
            gnt_num_q  <= '0;
            gnt_vld_q  <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_num_q  <= gnt_num_d;
            gnt_vld_q  <= gnt_vld_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_num_o   = gnt_num_q;
    assign gnt_valid_o = gnt_vld_q;
    assign timeout_o   = timeout_q;

    // Grant encoding must stay self-consistent.
    a_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(gnt_q));
    a_vld:    assert property (@(posedge clk_i) disable iff (rst_i) gnt_vld_q == (|gnt_q));
    a_num:    assert property (@(posedge clk_i) disable iff (rst_i)
                               gnt_vld_q ? gnt_q[gnt_num_q] : (gnt_num_q == '0));

endmodule
